// File: rtl/prisc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// prisc_pkg : shared datapath width, default requester count, FSM encoding
// Revision  : 1.0
// ---------------------------------------------------------------------------
package prisc_pkg;

  localparam int ADDER_W      = 32;
  localparam int NREQ_DEFAULT = 4;

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

endpackage : prisc_pkg
`default_nettype wire

// File: rtl/Adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Adder : unsigned W-bit adder with carry out of the top bit
// Revision : 1.0
// ---------------------------------------------------------------------------
module Adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum,
  output logic         o_carry
);

  assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b};

endmodule : Adder
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter : combinational round-robin grant, search starts at ptr+1
// Revision   : 1.0
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  int w_pos;

  // Offset NREQ lands back on ptr itself, so the last winner is lowest priority.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_pos   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_pos = (int'(i_ptr) + k) % NREQ;
      if (!o_any && i_req[w_pos]) begin
        o_grant[w_pos] = 1'b1;
        o_idx          = IDW'(w_pos);
        o_any          = 1'b1;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/adder_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adder_arbiter : round-robin sharing of one 32-bit Adder, 1-cycle registered result
// Revision      : 1.0
// ---------------------------------------------------------------------------
module adder_arbiter
  import prisc_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*ADDER_W-1:0] req_a,
  input  logic [NREQ*ADDER_W-1:0] req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [ADDER_W-1:0]      rsp_sum,
  output logic                    rsp_carry
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IDW-1:0]       r_ptr;
  logic [IDW-1:0]       r_id;
  logic [ADDER_W-1:0]   r_sum;
  logic                 r_carry;

  logic [NREQ-1:0]      w_grant;
  logic [IDW-1:0]       w_idx;
  logic                 w_any;
  logic                 w_slot_free;
  logic                 w_accept;
  logic [ADDER_W-1:0]   w_a;
  logic [ADDER_W-1:0]   w_b;
  logic [ADDER_W-1:0]   w_sum;
  logic                 w_carry;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Operand mux feeds the single shared adder; only the winner's pair matters.
  assign w_a = req_a[w_idx*ADDER_W +: ADDER_W];
  assign w_b = req_b[w_idx*ADDER_W +: ADDER_W];

  Adder #(
    .W (ADDER_W)
  ) u_adder (
    .i_a     (w_a),
    .i_b     (w_b),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  assign w_slot_free = (r_state == S_EMPTY) || rsp_ready;
  assign w_accept    = w_any && w_slot_free;
  assign req_ready   = w_grant & {NREQ{w_slot_free & rst_n}};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
      S_FULL:  if (rsp_ready) w_state_nxt = w_accept ? S_FULL : S_EMPTY;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Requester 0 gets first priority out of reset because the search starts at ptr+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= IDW'(NREQ - 1);
      r_id    <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else if (w_accept) begin
      r_ptr   <= w_idx;
      r_id    <= w_idx;
      r_sum   <= w_sum;
      r_carry <= w_carry;
    end
  end

  assign rsp_valid = (r_state == S_FULL);
  assign rsp_id    = r_id;
  assign rsp_sum   = r_sum;
  assign rsp_carry = r_carry;

endmodule : adder_arbiter
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_adder_arbiter : directed self-checking bench for adder_arbiter (NREQ=4)
// Revision         : 1.0
// ---------------------------------------------------------------------------
module tb_adder_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [31:0]       rsp_sum;
  logic              rsp_carry;

  int checks = 0;
  int errors = 0;

  adder_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
    repeat (2) @(negedge clk);
    req_valid = 4'b1001;
    set_op(0, 32'd1, 32'd2);
    set_op(3, 32'd10, 32'd20);
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready got %b want 0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_sum !== 32'd0 || rsp_id !== 2'd0 || rsp_carry !== 1'b0)
      begin errors++; $display("FAIL rst_regs got id %0d sum %h c %b want 0", rsp_id, rsp_sum, rsp_carry); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_first_grant got %b want 0001", req_ready); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 32'd3)
      begin errors++; $display("FAIL rst_first_rsp got v %b id %0d sum %h want 1 0 3", rsp_valid, rsp_id, rsp_sum); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_full_ready got %b want 0000", req_ready); end
    rsp_ready = 1'b1; #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL rst_second_grant got %b want 1000", req_ready); end
    @(negedge clk); rsp_ready = 1'b0; #1;
    checks++; if (rsp_id !== 2'd3 || rsp_sum !== 32'd30)
      begin errors++; $display("FAIL rst_second_rsp got id %0d sum %h want 3 1e", rsp_id, rsp_sum); end
    rst_n = 1'b0; #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_sum !== 32'd0 || rsp_id !== 2'd0 || req_ready !== 4'b0000)
      begin errors++; $display("FAIL rst_midfull got v %b sum %h id %0d rdy %b want 0", rsp_valid, rsp_sum, rsp_id, req_ready); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_ptr_reinit got %b want 0001", req_ready); end
    req_valid = '0; rsp_ready = 1'b1;
    @(negedge clk); #1;
  endtask

  task automatic test_single();
    rsp_ready = 1'b0; req_valid = 4'b0100;
    set_op(2, 32'h0000_0005, 32'h0000_0007);
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant got %b want 0100", req_ready); end
    @(negedge clk); req_valid = '0; #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 32'h0000_000C || rsp_carry !== 1'b0)
      begin errors++; $display("FAIL single_rsp got v %b id %0d sum %h c %b want 1 2 c 0", rsp_valid, rsp_id, rsp_sum, rsp_carry); end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b want 0", rsp_valid); end
  endtask

  task automatic test_wrap();
    rsp_ready = 1'b0; req_valid = 4'b0010;
    set_op(1, 32'hFFFF_FFFF, 32'h0000_0001);
    @(negedge clk); #1;
    checks++; if (rsp_id !== 2'd1 || rsp_sum !== 32'h0 || rsp_carry !== 1'b1)
      begin errors++; $display("FAIL wrap_ones got id %0d sum %h c %b want 1 0 1", rsp_id, rsp_sum, rsp_carry); end
    rsp_ready = 1'b1; req_valid = 4'b0001;
    set_op(0, 32'h8000_0000, 32'h8000_0000);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_grant got %b want 0001", req_ready); end
    @(negedge clk); req_valid = '0; #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 32'h0 || rsp_carry !== 1'b1)
      begin errors++; $display("FAIL wrap_msb got v %b id %0d sum %h c %b want 1 0 0 1", rsp_valid, rsp_id, rsp_sum, rsp_carry); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wrap_drain got %b want 0", rsp_valid); end
  endtask

  task automatic test_fairness();
    int exp_id;
    rst_n = 1'b0; #1; rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_op(i, 32'(i * 100), 32'd1);
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      exp_id = k % NREQ;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== IDW'(exp_id) || rsp_sum !== 32'(exp_id * 100 + 1))
        begin errors++; $display("FAIL fair_step%0d got v %b id %0d sum %0d want 1 %0d %0d", k, rsp_valid, rsp_id, rsp_sum, exp_id, exp_id * 100 + 1); end
    end
    req_valid = '0;
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL fair_drain got %b want 0", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    req_valid = 4'b1111; rsp_ready = 1'b0;
    repeat (5) begin
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 32'd1 || req_ready !== 4'b0000)
        begin errors++; $display("FAIL bp_hold got v %b id %0d sum %0d rdy %b want 1 0 1 0000", rsp_valid, rsp_id, rsp_sum, req_ready); end
    end
    rsp_ready = 1'b1; #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_grant got %b want 0010", req_ready); end
    @(negedge clk); req_valid = '0; #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 32'd101)
      begin errors++; $display("FAIL bp_next got v %b id %0d sum %0d want 1 1 101", rsp_valid, rsp_id, rsp_sum); end
    @(negedge clk); #1;
  endtask

  task automatic test_withdrawal();
    rsp_ready = 1'b0; req_valid = 4'b0001;
    set_op(0, 32'd7, 32'd8);
    set_op(1, 32'd3, 32'd4);
    @(negedge clk); req_valid = 4'b0010; #1;
    checks++; if (rsp_id !== 2'd0 || rsp_sum !== 32'd15 || req_ready !== 4'b0000)
      begin errors++; $display("FAIL wd_hold got id %0d sum %0d rdy %b want 0 15 0000", rsp_id, rsp_sum, req_ready); end
    @(negedge clk); #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL wd_wait got %b want 0000", req_ready); end
    req_valid = '0; rsp_ready = 1'b1;
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wd_no_rsp got v %b id %0d want 0", rsp_valid, rsp_id); end
    req_valid = 4'b0011; #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL wd_ptr got %b want 0010", req_ready); end
    @(negedge clk); req_valid = '0; #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 32'd7)
      begin errors++; $display("FAIL wd_after got v %b id %0d sum %0d want 1 1 7", rsp_valid, rsp_id, rsp_sum); end
    @(negedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_fairness();
    test_back_to_back();
    test_withdrawal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks %0d", checks);
    $fatal(1);
  end

endmodule : tb_adder_arbiter
`default_nettype wire

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin scheduler that shares one 32-bit `Adder` datapath among NREQ requesters in the pRISC core, such as PC increment, branch-target and address-generation paths. It accepts at most one operand pair per cycle through valid/ready handshakes and registers the 33-bit result with the winner's ID. The result is presented on a single valid/ready response port. Sustained throughput is one addition per cycle; latency is one cycle.

## Interface
- NREQ, default 4: number of requesters; must be ≥2.
- IDW, default $clog2(NREQ): requester ID width (derived; do not override).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_a  in  NREQ*32  operand A; requester i at [i*32 +: 32].
- req_b  in  NREQ*32  operand B; same packing.
- rsp_valid  out  1  result register holds a result.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_sum  out  32  a+b modulo 2^32.
- rsp_carry  out  1  carry out of bit 31.

## Operation
- FSM states:
  - EMPTY: output register invalid.
  - FULL: rsp_valid=1.
- Slot is free when state==EMPTY, or when FULL && rsp_ready.
- Grant: round-robin over req_valid, starting at ptr+1 mod NREQ and wrapping.
  - req_ready[g] = grant[g] & slot_free & rst_n. This path is combinational from req_valid/rsp_ready.
- Accept (req_valid[g] & req_ready[g]):
  - Capture {rsp_carry,rsp_sum} <= {1'b0,a_g}+{1'b0,b_g} via `Adder`.
  - rsp_id <= g; ptr <= g.
  - Next state FULL.
- Transitions:
  - EMPTY & no request -> EMPTY.
  - EMPTY & accept -> FULL.
  - FULL & !rsp_ready -> FULL, all outputs frozen, all req_ready=0.
  - FULL & rsp_ready & accept -> FULL with new result (back-to-back).
  - FULL & rsp_ready & no request -> EMPTY.
- ptr changes only on accept. An ungranted requester waits at most NREQ-1 accepts.
- Requesters hold a/b stable while valid & !ready. Dropping valid before ready is permitted (no commitment).
- Wrap-around: 0xFFFF_FFFF + 1 gives sum 0x0000_0000, carry 1. Carry is unsigned only; no overflow flag.
- Reset (async, any state): state=EMPTY, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_carry=0, ptr=NREQ-1 (requester 0 has first priority). req_ready=0 while rst_n=0. An undelivered result is discarded.

## Timing
- Accept at edge N gives rsp_valid=1 with data after edge N, i.e. visible in cycle N+1.
- Result is consumed at the first edge where rsp_valid & rsp_ready.
- The same edge may consume one result and accept the next (full throughput).
- No combinational path from req_a/req_b to any output. rsp_* are registered.
- Reset release is synchronised externally. The first accept is possible in the first cycle after rst_n rises.

## Structure
- Shared package/header `prisc_pkg`:
  - ADDER_W=32
  - default NREQ
  - FSM state localparams: S_EMPTY=1'b0, S_FULL=1'b1.
- Sub-module `rr_arbiter` (NREQ, IDW):
  - inputs: req vector, ptr.
  - outputs: one-hot grant, binary grant index, any.
  - Purely combinational.
- The existing `Adder` is instantiated once, fed by a mux on the grant index. There are no other adders in the block.

## Test plan
- Reset: assert rst_n=0 mid-FULL with rsp_ready=0 -> rsp_valid=0, rsp_sum=0, rsp_id=0 immediately; after release, req 0 and req 3 both valid -> req 0 granted first.
- Single request: req 2 with a=0x0000_0005, b=0x0000_0007 -> next cycle rsp_valid=1, rsp_id=2, rsp_sum=0x0000_000C, rsp_carry=0.
- Wrap: a=0xFFFF_FFFF, b=0x0000_0001 -> rsp_sum=0, rsp_carry=1; a=0x8000_0000, b=0x8000_0000 -> sum 0, carry 1.
- Fairness: all four requesters continuously valid, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1,… one result per cycle, no gaps.
- Backpressure: rsp_ready=0 for 5 cycles while FULL -> rsp_* stable, req_ready=0 all cycles; rsp_ready=1 -> same result consumed, next grant in the same cycle.
- Withdrawal: req 1 valid then dropped before grant while req 0 holds the slot -> no response with rsp_id=1; ptr unchanged by the withdrawal.
